// File: rtl/anton_neopixel_stream_decoder.sv
// WS2812-style single-wire receiver: synchronizes the raw line, measures high
// pulse widths to recover bits, assembles MSB-first 24-bit pixels and reports
// frame boundaries, pixel counts and protocol errors.
module anton_neopixel_stream_decoder #(
    parameter int BUFFER_END    = 63,
    parameter int RESET_DELAY   = 320,
    parameter int BIT_THRESHOLD = 4,
    parameter int MAX_HIGH      = 7,
    localparam int BUFFER_BITS  = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1
) (
    input  logic                   clk6_4mhz,
    input  logic                   rst,
    input  logic                   stream_in,
    input  logic                   enable,
    output logic [23:0]            pixel_data,
    output logic [BUFFER_BITS-1:0] pixel_index,
    output logic                   pixel_valid,
    output logic                   frame_done,
    output logic [BUFFER_BITS:0]   frame_pixels,
    output logic                   error,
    output logic                   locked
);

    localparam logic [11:0]          RESET_DELAY_C = 12'(RESET_DELAY);
    localparam logic [3:0]           THRESHOLD_C   = 4'(BIT_THRESHOLD);
    localparam logic [3:0]           MAX_HIGH_C    = 4'(MAX_HIGH);
    localparam logic [BUFFER_BITS:0] PIX_LIMIT_C   = (BUFFER_BITS + 1)'(BUFFER_END + 1);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t                 state_q;
    logic                   syncMeta_q;
    logic                   syncLine_q;
    logic                   linePrev_q;
    logic [11:0]            lowCnt_q;
    logic [11:0]            lowCnt_d;
    logic [3:0]             highCnt_q;
    logic [3:0]             highCnt_d;
    logic [4:0]             bitCnt_q;
    logic [23:0]            shift_q;
    logic                   pend_q;
    logic [BUFFER_BITS:0]   pixCnt_q;
    logic [23:0]            pixelData_q;
    logic [BUFFER_BITS-1:0] pixelIndex_q;
    logic                   pixelValid_q;
    logic                   frameDone_q;
    logic [BUFFER_BITS:0]   framePixels_q;
    logic                   error_q;

    assign pixel_data   = pixelData_q;
    assign pixel_index  = pixelIndex_q;
    assign pixel_valid  = pixelValid_q;
    assign frame_done   = frameDone_q;
    assign frame_pixels = framePixels_q;
    assign error        = error_q;
    assign locked       = (state_q != SYNC);

    // Two-flop synchronizer plus a delayed copy of the synced line for edge detection.
    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            syncMeta_q <= 1'b0;
            syncLine_q <= 1'b0;
            linePrev_q <= 1'b0;
        end else begin
            syncMeta_q <= stream_in;
            syncLine_q <= syncMeta_q;
            linePrev_q <= syncLine_q;
        end
    end

    // Saturating run lengths: low ticks since last high, high ticks of the current pulse.
    always_comb begin
        lowCnt_d  = lowCnt_q;
        highCnt_d = highCnt_q;
        if (syncLine_q) begin
            lowCnt_d = '0;
            if (!linePrev_q) begin
                highCnt_d = 4'd1;
            end else if (highCnt_q != 4'hF) begin
                highCnt_d = highCnt_q + 4'd1;
            end
        end else if (lowCnt_q != 12'hFFF) begin
            lowCnt_d = lowCnt_q + 12'd1;
        end
    end

    // Register the run-length counters.
    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            lowCnt_q  <= '0;
            highCnt_q <= '0;
        end else begin
            lowCnt_q  <= lowCnt_d;
            highCnt_q <= highCnt_d;
        end
    end

    // Decoder FSM: classifies pulses, emits pixels one cycle after the 24th bit, detects frame ends.
    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            state_q       <= SYNC;
            bitCnt_q      <= '0;
            shift_q       <= '0;
            pend_q        <= 1'b0;
            pixCnt_q      <= '0;
            pixelData_q   <= '0;
            pixelIndex_q  <= '0;
            pixelValid_q  <= 1'b0;
            frameDone_q   <= 1'b0;
            framePixels_q <= '0;
            error_q       <= 1'b0;
        end else begin
            pixelValid_q <= 1'b0;
            frameDone_q  <= 1'b0;
            error_q      <= 1'b0;
            if (!enable) begin
                state_q  <= SYNC;
                pend_q   <= 1'b0;
                bitCnt_q <= '0;
            end else begin
                if (pend_q) begin
                    pend_q <= 1'b0;
                    if (pixCnt_q == PIX_LIMIT_C) begin
                        error_q <= 1'b1;
                    end else begin
                        pixelValid_q <= 1'b1;
                        pixelData_q  <= shift_q;
                        pixelIndex_q <= pixCnt_q[BUFFER_BITS-1:0];
                        pixCnt_q     <= pixCnt_q + 1'b1;
                    end
                end
                case (state_q)
                    SYNC: begin
                        if (lowCnt_q >= RESET_DELAY_C) begin
                            state_q <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (syncLine_q) begin
                            state_q  <= HIGH;
                            bitCnt_q <= '0;
                            pixCnt_q <= '0;
                        end
                    end
                    HIGH: begin
                        if (highCnt_q > MAX_HIGH_C) begin
                            error_q  <= 1'b1;
                            bitCnt_q <= '0;
                            state_q  <= SYNC;
                        end else if (!syncLine_q) begin
                            shift_q <= {shift_q[22:0], (highCnt_q >= THRESHOLD_C)};
                            if (bitCnt_q == 5'd23) begin
                                bitCnt_q <= '0;
                                pend_q   <= 1'b1;
                            end else begin
                                bitCnt_q <= bitCnt_q + 5'd1;
                            end
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        if (syncLine_q) begin
                            state_q <= HIGH;
                        end else if (lowCnt_q == RESET_DELAY_C) begin
                            frameDone_q   <= 1'b1;
                            framePixels_q <= pixCnt_q;
                            error_q       <= (bitCnt_q != 5'd0);
                            bitCnt_q      <= '0;
                            state_q       <= IDLE;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: doc/anton_neopixel_stream_decoder.md
Name: anton_neopixel_stream_decoder

Overview:
Receive-side counterpart of the NeoPixel stream logic. Samples a WS2812-style single-wire data line in the clk6_4mhz domain, classifies each high pulse by width into a 0 or 1 bit, and assembles MSB-first 24-bit pixels. Emits each pixel with its buffer index and reports end of frame when the line stays low for RESET_DELAY ticks. Used for loopback self-test of the transmitter and as the front end of a daisy-chain input port.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid pixel index; BUFFER_BITS = `CLOG2(BUFFER_END+1)
RESET_DELAY, `RESET_DELAY_DEFAULT, consecutive low ticks that mark a frame reset/sync
BIT_THRESHOLD, 4, high width in ticks at or above which the bit decodes as 1
MAX_HIGH, 7, longest legal high width in ticks; longer is a protocol error

Ports:
clk6_4mhz  input  1  sole clock, 6.4 MHz (8 ticks per bit period)
rst  input  1  synchronous, active-high reset
stream_in  input  1  raw serial line, asynchronous to clk6_4mhz
enable  input  1  decoder runs when 1; when 0, held in SYNC state
pixel_data  output  24  last completed pixel, bit 23 first received
pixel_index  output  BUFFER_BITS  index of pixel_data
pixel_valid  output  1  one-cycle strobe, pixel_data/pixel_index valid
frame_done  output  1  one-cycle strobe at reset detection after at least one bit
frame_pixels  output  BUFFER_BITS+1  pixels emitted in the frame just ended, valid with frame_done
error  output  1  one-cycle strobe on any protocol violation
locked  output  1  1 when not in SYNC state

Behaviour:
- Input: 2-flop synchronizer, then edge detect on the synced value. Both edges are delayed equally, so widths are preserved. All timing below uses the synced value s.
- Reset (rst=1 at a clock edge): state=SYNC; all counters 0; pixel_data=0; pixel_index=0; frame_pixels=0; all strobes 0; locked=0. This applies at any point, including mid-pixel, and discards partial data.
- low_cnt: 12 bits, saturating. Increments each tick s=0 and clears on s=1.
- high_cnt: 4 bits, saturating at 15. Set to 1 on the first tick s=1 and increments while s=1.
- States:
  - SYNC: ignore pulses. When low_cnt reaches RESET_DELAY, go to IDLE. enable=0 forces SYNC from any state.
  - IDLE: line low, frame boundary. On s=1, go to HIGH and clear bit_cnt, pixel count and index.
  - HIGH: count high_cnt. On s=0, classify the bit:
    - width <BIT_THRESHOLD → 0; BIT_THRESHOLD..MAX_HIGH → 1.
    - Shift the bit into the shift register, bit_cnt+1, go to LOW.
    - If high_cnt exceeds MAX_HIGH while in HIGH: error strobe, drop the partial pixel, go to SYNC.
  - LOW: on s=1, go to HIGH. When low_cnt == RESET_DELAY:
    - frame_done=1 next cycle with frame_pixels = pixels emitted.
    - If bit_cnt != 0, error=1 in the same cycle and the partial pixel is discarded.
    - Go to IDLE.
- Pixel completion: when the 24th bit is classified (bit_cnt 23→0), on the next cycle pixel_valid=1, pixel_data = 24-bit shift result, pixel_index = current index; the index then increments.
- Overflow: if a pixel completes when emitted count already equals BUFFER_END+1:
  - no pixel_valid; error=1.
  - index stays at BUFFER_END; decoding continues to frame end.
  - frame_pixels saturates at BUFFER_END+1.
- Simultaneous events:
  - pixel_valid and frame_done never coincide, because a complete pixel strobes at least RESET_DELAY-1 cycles before reset detection.
  - error and frame_done may coincide (partial pixel at reset).
- Latency: pixel_valid occurs 4 cycles after the raw falling edge of bit 23 (2 sync, 1 classify, 1 register).
- frame_done only fires if at least one rising edge was seen since IDLE. An idle line produces no repeated strobes.

Test Plan:
- Lock: rst, then stream_in low 10 ticks then a valid pulse → ignored, no strobes. Hold low RESET_DELAY ticks → locked=1.
- Single pixel: after lock, send 0xA5C3F0 using 2-tick highs for 0 and 5-tick highs for 1 (8-tick bits), then low RESET_DELAY → pixel_valid once with data=0xA5C3F0, index=0; then frame_done with frame_pixels=1; error never.
- Threshold and error: a 3-tick high decodes as 0 and a 4-tick high as 1. A 9-tick high → error, locked=0, no pixel_valid until re-lock.
- Partial frame: 2 pixels plus 10 bits, then reset gap → two pixel_valid at index 0,1; then frame_done with frame_pixels=2 and error in the same cycle.
- Overflow: BUFFER_END=3, send 5 pixels → indices 0..3 strobed; 5th pixel gives error without pixel_valid; frame_pixels=4.
- Reset mid-pixel: assert rst after 12 bits → all outputs 0, state SYNC. The next frame after re-lock decodes correctly from index 0.
